// File: rtl/dcache_data_memory.sv
// Off-chip line memory behind the data cache: whole 256-bit lines, fixed
// request-to-ack latency over an enable/write/ack handshake.
module dcache_data_memory #(
    parameter int INDEX_W = 9,
    parameter int LATENCY = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

    state_e               state_q;
    logic [7:0]           cnt_q;
    logic [INDEX_W-1:0]   idx_q;
    logic                 wr_q;
    logic [255:0]         wdata_q;
    logic [255:0]         rdata_q;
    logic                 ack_q;
    logic                 commit;

    logic [255:0] mem_q [2**INDEX_W];

    // The access happens on the last WAIT edge; an abort on that same edge wins.
    assign commit = (state_q == WAIT) && enable_i && (cnt_q == 8'd1);

    always_ff @(posedge clk_i) begin
        if (commit && wr_q) mem_q[idx_q] <= wdata_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            // ack trails the ACK state by one edge, landing after edge LATENCY
            // while the FSM is already back in IDLE and can accept again.
            ack_q <= (state_q == ACK);
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        idx_q   <= addr_i[INDEX_W+4:5];
                        wr_q    <= write_i;
                        wdata_q <= data_i;
                        cnt_q   <= 8'(LATENCY - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!enable_i) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cnt_q != 8'd1) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        rdata_q <= wr_q ? wdata_q : mem_q[idx_q];
                        cnt_q   <= '0;
                        state_q <= ACK;
                    end
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;

endmodule

// File: tb/tb_dcache_data_memory.sv
// Self-checking bench for dcache_data_memory: directed scenarios plus a
// randomized read/write mix against an array-based line model.
module tb_dcache_data_memory;

    localparam int INDEX_W = 9;
    localparam int LAT     = 10;
    localparam int DEPTH   = 2**INDEX_W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         en;
    logic         wr;
    logic         ack;
    logic [255:0] dout;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [255:0] model [DEPTH];
    bit           written [DEPTH];

    dcache_data_memory #(.INDEX_W(INDEX_W), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(wdata),
        .enable_i(en), .write_i(wr), .ack_o(ack), .data_o(dout)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32) % DEPTH);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One full transaction: accept on the first edge after setup, count edges
    // until ack is seen, drop enable in the ack cycle.
    task automatic do_req(input logic [31:0] a, input logic w, input logic [255:0] d,
                          output int lat, output logic [255:0] q);
        @(posedge clk); #1;
        addr = a; wr = w; wdata = d; en = 1'b1;
        @(posedge clk);
        lat = -1; q = '0;
        for (int k = 1; k <= LAT + 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (ack === 1'b1) begin lat = k; q = dout; break; end
        end
        en = 1'b0;
        if (w) begin model[idx_of(a)] = d; written[idx_of(a)] = 1'b1; end
    endtask

    task automatic test_reset();
        total_cnt++;
        if (ack !== 1'b0) $display("FAIL reset_ack got=%b want=0", ack); else pass_cnt++;
        total_cnt++;
        if (dout !== '0) $display("FAIL reset_data got=%h want=0", dout); else pass_cnt++;
    endtask

    task automatic test_read_latency();
        int lat; logic [255:0] q, a5;
        a5 = {32{8'hA5}};
        do_req(32'h60, 1'b1, a5, lat, q);
        do_req(32'h60, 1'b0, '0, lat, q);
        total_cnt++;
        if (lat !== LAT) $display("FAIL read_latency got=%0d want=%0d", lat, LAT); else pass_cnt++;
        total_cnt++;
        if (q !== a5) $display("FAIL read_data got=%h want=%h", q, a5); else pass_cnt++;
        @(posedge clk); @(negedge clk);
        total_cnt++;
        if (ack !== 1'b0) $display("FAIL ack_one_cycle got=%b want=0", ack); else pass_cnt++;
        total_cnt++;
        if (dout !== a5) $display("FAIL data_hold got=%h want=%h", dout, a5); else pass_cnt++;
    endtask

    task automatic test_write_read();
        int lat; logic [255:0] q, w;
        w = {8{32'h1234_5678}};
        do_req(32'h80, 1'b1, w, lat, q);
        total_cnt++;
        if (lat !== LAT || q !== w) $display("FAIL write_ack lat=%0d want=%0d data=%h", lat, LAT, q); else pass_cnt++;
        do_req(32'h80, 1'b0, '0, lat, q);
        total_cnt++;
        if (q !== w) $display("FAIL write_then_read got=%h want=%h", q, w); else pass_cnt++;
    endtask

    task automatic test_aliasing();
        int lat; logic [255:0] q, v;
        v = rand_line();
        do_req(32'h0000_403F, 1'b1, v, lat, q);
        do_req(32'h20, 1'b0, '0, lat, q);
        total_cnt++;
        if (q !== model[1]) $display("FAIL alias_read got=%h want=%h", q, model[1]); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat, lat2; logic [255:0] q, w, held;
        w = rand_line();
        @(posedge clk); #1;
        addr = 32'h400; wr = 1'b1; wdata = w; en = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= LAT + 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (ack === 1'b1) begin lat = k; break; end
        end
        model[idx_of(32'h400)] = w;
        wr = 1'b0; addr = 32'h20;
        total_cnt++;
        if (lat !== LAT) $display("FAIL b2b_write_lat got=%0d want=%0d", lat, LAT); else pass_cnt++;
        @(posedge clk);
        lat2 = -1; q = '0;
        for (int k = 1; k <= LAT + 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (ack === 1'b1) begin lat2 = k; q = dout; break; end
        end
        total_cnt++;
        if (lat2 !== LAT) $display("FAIL b2b_fill_lat got=%0d want=%0d", lat2, LAT); else pass_cnt++;
        total_cnt++;
        if (q !== model[1]) $display("FAIL b2b_fill_data got=%h want=%h", q, model[1]); else pass_cnt++;
        // enable still high: spurious accept on the next edge, then dropped
        held = q;
        @(posedge clk); #1; en = 1'b0;
        lat = -1;
        for (int k = 0; k < 2*LAT; k++) begin
            @(posedge clk); @(negedge clk);
            if (ack === 1'b1) lat = k;
        end
        total_cnt++;
        if (lat !== -1) $display("FAIL spurious_abort_ack got=ack_at_%0d want=none", lat); else pass_cnt++;
        total_cnt++;
        if (dout !== held) $display("FAIL spurious_abort_data got=%h want=%h", dout, held); else pass_cnt++;
        do_req(32'h400, 1'b0, '0, lat, q);
        total_cnt++;
        if (q !== w) $display("FAIL b2b_wb_stored got=%h want=%h", q, w); else pass_cnt++;
    endtask

    task automatic test_abort();
        int lat; logic [255:0] q, v1, v2;
        v1 = rand_line(); v2 = ~v1;
        do_req(32'h40, 1'b1, v1, lat, q);
        @(posedge clk); #1;
        addr = 32'h40; wr = 1'b1; wdata = v2; en = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 en = 1'b0;
        lat = -1;
        for (int k = 0; k < 2*LAT; k++) begin
            @(posedge clk); @(negedge clk);
            if (ack === 1'b1) lat = k;
        end
        total_cnt++;
        if (lat !== -1) $display("FAIL abort_ack got=ack_at_%0d want=none", lat); else pass_cnt++;
        total_cnt++;
        if (dout !== v1) $display("FAIL abort_data_o got=%h want=%h", dout, v1); else pass_cnt++;
        do_req(32'h40, 1'b0, '0, lat, q);
        total_cnt++;
        if (lat !== LAT) $display("FAIL abort_next_lat got=%0d want=%0d", lat, LAT); else pass_cnt++;
        total_cnt++;
        if (q !== v1) $display("FAIL abort_array got=%h want=%h", q, v1); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat; logic [255:0] q, v1, v2;
        v1 = rand_line() | 256'h1; v2 = ~v1;
        do_req(32'hA0, 1'b1, v1, lat, q);
        @(posedge clk); #1;
        addr = 32'hA0; wr = 1'b1; wdata = v2; en = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (ack !== 1'b0) $display("FAIL rst_mid_ack got=%b want=0", ack); else pass_cnt++;
        total_cnt++;
        if (dout !== '0) $display("FAIL rst_mid_data got=%h want=0", dout); else pass_cnt++;
        @(negedge clk); rst_n = 1'b1; en = 1'b0;
        lat = -1;
        for (int k = 0; k < 2*LAT; k++) begin
            @(posedge clk); @(negedge clk);
            if (ack === 1'b1) lat = k;
        end
        total_cnt++;
        if (lat !== -1) $display("FAIL rst_mid_stray_ack got=ack_at_%0d want=none", lat); else pass_cnt++;
        do_req(32'hA0, 1'b0, '0, lat, q);
        total_cnt++;
        if (lat !== LAT || q !== v1) $display("FAIL rst_mid_read lat=%0d data=%h want_data=%h", lat, q, v1); else pass_cnt++;
    endtask

    task automatic test_random();
        int lat, ix; logic [255:0] q, v, exp; logic [31:0] a; logic w;
        for (int n = 0; n < 30; n++) begin
            ix = int'($urandom_range(16, 31));
            a  = 32'(ix * 32) | ($urandom % 32) | (32'($urandom_range(0, 7)) << 14);
            w  = !written[ix] || ($urandom % 2 == 0);
            v  = rand_line();
            exp = w ? v : model[ix];
            do_req(a, w, v, lat, q);
            total_cnt++;
            if (lat !== LAT) $display("FAIL rand_lat[%0d] got=%0d want=%0d", n, lat, LAT); else pass_cnt++;
            total_cnt++;
            if (q !== exp) $display("FAIL rand_data[%0d] got=%h want=%h", n, q, exp); else pass_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin model[i] = '0; written[i] = 1'b0; end
        #12;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        test_read_latency();
        test_write_read();
        test_aliasing();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
